// File: rtl/axis_slave_fifo.sv
// AXI4-Stream slave feeding a backend port through a first-word-fall-through FIFO,
// with optional store-and-forward release of complete packets.
module axis_slave_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int PKT_MODE   = 0,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    input  logic                      axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0]   axis_tkeep,
    input  logic                      axis_tlast,
    input  logic [USER_WIDTH-1:0]     axis_tuser,
    output logic                      axis_tready,
    output logic [DATA_WIDTH-1:0]     bk_data,
    output logic [DATA_WIDTH/8-1:0]   bk_tstrb,
    output logic [DATA_WIDTH/8-1:0]   bk_tkeep,
    output logic [USER_WIDTH-1:0]     bk_user,
    output logic                      bk_tlast,
    output logic                      bk_valid,
    input  logic                      bk_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    pkt_cnt
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 2 * SW + USER_WIDTH + 1;

    logic [EW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic [LW-1:0]         level_next;
    logic [LW-1:0]         pkt_cnt_reg;
    logic [LW-1:0]         pkt_cnt_next;
    logic                  af_reg;

    logic                  wr_en;
    logic                  rd_en;
    logic                  full;
    logic                  release_ok;
    logic                  pkt_in;
    logic                  pkt_out;

    logic [DATA_WIDTH-1:0] head_data;
    logic [SW-1:0]         head_strb;
    logic [SW-1:0]         head_keep;
    logic [USER_WIDTH-1:0] head_user;
    logic                  head_last;

    // Handshakes are derived only from registered state, so there is no
    // combinational path from bk_ready to axis_tready.
    assign full        = (level_reg == LW'(DEPTH));
    assign axis_tready = !axi_reset && !full;
    assign wr_en       = axis_tvalid && axis_tready;

    // In packet mode the full term lets an oversize packet drain cut-through.
    assign release_ok  = (PKT_MODE == 0) || (pkt_cnt_reg != '0) || full;
    assign bk_valid    = !axi_reset && (level_reg != '0) && release_ok;
    assign rd_en       = bk_valid && bk_ready;

    assign {head_data, head_strb, head_keep, head_user, head_last} = mem[rd_ptr_reg];

    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
        end
    end

    assign pkt_in  = wr_en && axis_tlast;
    assign pkt_out = rd_en && head_last;

    always_comb begin
        level_next = level_reg;
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        pkt_cnt_next = pkt_cnt_reg;
        case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt_next = pkt_cnt_reg + LW'(1);
            2'b01:   pkt_cnt_next = pkt_cnt_reg - LW'(1);
            default: pkt_cnt_next = pkt_cnt_reg;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            pkt_cnt_reg <= '0;
            af_reg      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg   <= level_next;
            pkt_cnt_reg <= pkt_cnt_next;
            af_reg      <= (level_next >= LW'(AF_LEVEL));
        end
    end

    assign level       = level_reg;
    assign pkt_cnt     = pkt_cnt_reg;
    assign almost_full = af_reg && !axi_reset;

    // Payload is forced to zero whenever no beat is being offered.
    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lane
            assign bk_data[gi*8 +: 8] = bk_valid ? head_data[gi*8 +: 8] : 8'd0;
            assign bk_tstrb[gi]       = bk_valid && head_strb[gi];
            assign bk_tkeep[gi]       = bk_valid && head_keep[gi];
        end
    endgenerate

    assign bk_user  = bk_valid ? head_user : '0;
    assign bk_tlast = bk_valid && head_last;

endmodule
